// File: rtl/uart_tx_buffered_pkg.sv
// Shared encodings for the buffered UART transmitter: status bit positions,
// register selects and FSM state codes.
package uart_tx_buffered_pkg;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;

   localparam logic REG_TXDATA = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   function automatic logic [7:0] status_byte(input logic ovf, input logic busy,
                                              input logic full, input logic empty);
      logic [7:0] s;
      s           = '0;
      s[ST_OVF]   = ovf;
      s[ST_BUSY]  = busy;
      s[ST_FULL]  = full;
      s[ST_EMPTY] = empty;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate count.
module fifo_sync #(
   parameter int FIFO_AW = 4,
   parameter int WIDTH   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
   logic             push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                    (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage is deliberately left unreset; only the pointers define contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter: bus decode, sticky overflow status and
// the frame serialiser that drains the byte FIFO on the shared 16x tick.
//
// state | meaning
// IDLE  | line high; pops the FIFO head as soon as one is queued
// START | start bit (low) for OS_TICK ticks
// DATA  | DBIT data bits, LSB first, OS_TICK ticks each
// STOP  | stop bit (high) for SB_TICK ticks
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int OS_TICK = 16,
   parameter int FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       rd,
   input  logic       wr,
   input  logic       s_mmio,
   input  logic       s_io,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       tx
);
   localparam logic [3:0] OS_LAST  = 4'(OS_TICK - 1);
   localparam logic [3:0] SB_LAST  = 4'(SB_TICK - 1);
   localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);

   tx_state_e       state_q, state_d;
   logic [3:0]      tick_cnt_q, tick_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [DBIT-1:0] shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            ovf_q, ovf_d;
   logic            push_req, status_rd, fifo_pop, fifo_full, fifo_empty, busy;
   logic [7:0]      fifo_dout;

   assign push_req  = wr & s_mmio & (s_io == REG_TXDATA);
   assign status_rd = rd & s_mmio & (s_io == REG_STATUS);
   assign busy      = (state_q != S_IDLE);
   assign tx        = tx_q;
   assign data_out  = status_rd ? status_byte(ovf_q, busy, fifo_full, fifo_empty) : 8'h00;

   fifo_sync #(
      .FIFO_AW (FIFO_AW),
      .WIDTH   (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A dropped write uses the registered full flag, so a same-cycle pop cannot rescue it.
   always_comb begin
      ovf_d = ovf_q;
      if (status_rd)            ovf_d = 1'b0;
      if (push_req & fifo_full) ovf_d = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      fifo_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_dout[DBIT-1:0];
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (tick_cnt_q == OS_LAST) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = S_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tick_cnt_q == OS_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = shift_q >> 1;
                  if (bit_cnt_q == BIT_LAST) state_d = S_STOP;
                  else                       bit_cnt_d = bit_cnt_q + 3'd1;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tick_cnt_q == SB_LAST) state_d = S_IDLE;
               else                       tick_cnt_d = tick_cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx is registered from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: written bytes are queued as expected
// frames and a tick-counting line receiver pops and compares each decoded frame.
module tb_uart_tx_buffered;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       rd = 1'b0, wr = 1'b0, s_mmio = 1'b0, s_io = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       tx;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q [$];

   uart_tx_buffered dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .rd       (rd),
      .wr       (wr),
      .s_mmio   (s_mmio),
      .s_io     (s_io),
      .data_in  (data_in),
      .data_out (data_out),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   int tick_div = 1;
   bit tick_en  = 1'b0;
   int tick_ph  = 0;
   always @(posedge clk) begin
      #1;
      tick    = (tick_en && tick_ph == 0);
      tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference receiver: counts ticks consumed since the falling start edge and
   // samples the line mid-bit (tick 8 of every 16).
   int         cyc = 0;
   bit         rx_act = 1'b0;
   int         rx_c = 0, rx_last = -1, rx_start = 0, last_end = -1, last_dur = 0;
   int         rx_frames = 0;
   logic [7:0] rx_sh = 8'h00;
   bit         b2b_en = 1'b0;
   int         burst_start = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst !== 1'b1) begin
         rx_act = 1'b0;
      end else begin
         if (!rx_act && tx === 1'b0) begin
            rx_act   = 1'b1;
            rx_c     = 0;
            rx_last  = -1;
            rx_start = cyc;
            if (b2b_en && last_end > burst_start) chk("b2b_gap", cyc - last_end, 1);
         end
         if (rx_act) begin
            if (rx_c == 160) begin
               rx_act   = 1'b0;
               last_end = cyc;
               last_dur = cyc - rx_start;
               rx_frames++;
               chk("frame_queued", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) chk("frame_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
            end else begin
               if (rx_c != rx_last && rx_c % 16 == 8) begin
                  rx_last = rx_c;
                  if (rx_c == 8)        chk("start_bit", 32'(tx), 0);
                  else if (rx_c < 152)  rx_sh = {tx, rx_sh[7:1]};
                  else                  chk("stop_bit", 32'(tx), 1);
               end
               if (tick === 1'b1) rx_c++;
            end
         end
      end
   end

   task automatic bus_idle();
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0; s_mmio = 1'b0; s_io = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit keep);
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b1; s_mmio = 1'b1; s_io = 1'b0; data_in = b;
      if (keep) exp_q.push_back(b);
   endtask

   task automatic read_status(output logic [7:0] v);
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b1; s_mmio = 1'b1; s_io = 1'b1;
      @(negedge clk);
      v = data_out;
   endtask

   task automatic wait_drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rx_act) done = 1'b1;
      end
      chk("drain_done", 32'(done), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      bit         found;
      int         frames_before;

      // Reset held with ticks running and a status read in progress.
      tick_div = 1; tick_en = 1'b1;
      rd = 1'b1; s_mmio = 1'b1; s_io = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_tx", 32'(tx), 1);
         chk("reset_status", 32'(data_out), 'h01);
      end
      rst = 1'b1;
      bus_idle();
      @(negedge clk);
      chk("post_reset_tx", 32'(tx), 1);

      // Single byte, tick every 4 clk.
      tick_div = 4;
      write_byte(8'hA5, 1'b1);
      @(negedge clk);
      chk("tx_write_cycle", 32'(tx), 1);
      bus_idle();
      @(negedge clk);
      chk("tx_write_plus1", 32'(tx), 1);
      @(negedge clk);
      chk("tx_write_plus2", 32'(tx), 0);
      wait_drain(1000);
      chk("frame_len_640", 32'(last_dur >= 637 && last_dur <= 640), 1);
      read_status(v);
      bus_idle();
      chk("status_after_frame", 32'(v), 'h01);

      // Fill with ticks stopped: one byte sits in the shifter, sixteen in the FIFO.
      tick_en = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i), 1'b1);
      read_status(v);
      chk("status_full", 32'(v), 'h06);
      write_byte(8'hEE, 1'b0);
      read_status(v);
      chk("status_ovf", 32'(v), 'h0E);
      read_status(v);
      chk("status_ovf_cleared", 32'(v), 'h06);
      bus_idle();
      burst_start = cyc; b2b_en = 1'b1;
      tick_div = 1; tick_en = 1'b1;
      wait_drain(4000);
      b2b_en = 1'b0;

      // Back-to-back frames.
      tick_div = 2;
      burst_start = cyc; b2b_en = 1'b1;
      write_byte(8'h00, 1'b1);
      write_byte(8'hFF, 1'b1);
      write_byte(8'h3C, 1'b1);
      bus_idle();
      wait_drain(2000);
      b2b_en = 1'b0;

      // Push in the very cycle the FSM pops, with three bytes queued.
      tick_div = 1;
      write_byte(8'h40, 1'b1);
      write_byte(8'h41, 1'b1);
      write_byte(8'h42, 1'b1);
      write_byte(8'h43, 1'b1);
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b1; s_mmio = 1'b1; s_io = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (data_out[2] == 1'b0) begin
            found = 1'b1;
            rd = 1'b0; s_io = 1'b0; wr = 1'b1; data_in = 8'h44;
            exp_q.push_back(8'h44);
            tick_en = 1'b0;
         end
      end
      chk("pop_cycle_found", 32'(found), 1);
      bus_idle();
      for (int i = 0; i < 12; i++) write_byte(8'h50 + 8'(i), 1'b1);
      read_status(v);
      chk("count15_not_full", 32'(v), 'h04);
      write_byte(8'h5C, 1'b1);
      read_status(v);
      chk("count16_full", 32'(v), 'h06);
      bus_idle();
      burst_start = cyc; b2b_en = 1'b1;
      tick_en = 1'b1;
      wait_drain(4000);
      b2b_en = 1'b0;

      // Reset mid-frame; bit 5 of 0x55 drives low so the async return to idle is visible.
      tick_div = 4;
      write_byte(8'h55, 1'b1);
      write_byte(8'h66, 1'b1);
      write_byte(8'h77, 1'b1);
      bus_idle();
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (rx_act && rx_c >= 104) found = 1'b1;
      end
      chk("reached_bit5", 32'(found), 1);
      #2;
      chk("tx_before_reset", 32'(tx), 0);
      rst = 1'b0;
      #1;
      chk("tx_async_reset", 32'(tx), 1);
      exp_q.delete();
      frames_before = rx_frames;
      repeat (3) begin
         @(negedge clk);
         chk("tx_in_reset", 32'(tx), 1);
      end
      rst = 1'b1;
      read_status(v);
      bus_idle();
      chk("status_after_abort", 32'(v), 'h01);
      repeat (800) @(negedge clk);
      chk("no_frame_after_reset", rx_frames, frames_before);
      chk("tx_idle_after_reset", 32'(tx), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
